// File: rtl/conv_layer_sched_if.sv
// Descriptor push channel between the host and the layer scheduler.
// A descriptor transfers on a rising clk edge where desc_valid && desc_ready; the host holds the fields stable while desc_valid is high and desc_ready is low.
interface conv_layer_sched_if #(
  parameter int CHN_WIDTH = 4,
  parameter int FMS_WIDTH = 8
);
  logic                 desc_valid;
  logic                 desc_ready;
  logic [CHN_WIDTH-1:0] desc_ci;
  logic [CHN_WIDTH-1:0] desc_co;
  logic                 desc_stride;
  logic                 desc_group;
  logic [FMS_WIDTH-1:0] desc_ifm_size;

  modport master (
    output desc_valid, desc_ci, desc_co, desc_stride, desc_group, desc_ifm_size,
    input  desc_ready
  );

  modport slave (
    input  desc_valid, desc_ci, desc_co, desc_stride, desc_group, desc_ifm_size,
    output desc_ready
  );
endinterface

// File: rtl/conv_layer_sched.sv
// Layer scheduler: queues layer descriptors and launches them one at a time on the
// conv2d_3x3 engine, with a completion counter and a sticky watchdog error.
module conv_layer_sched #(
  parameter int CHN_WIDTH = 4,
  parameter int FMS_WIDTH = 8,
  parameter int DEPTH     = 4,
  parameter int TMO_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   sched_en,
  conv_layer_sched_if.slave      desc,
  input  logic [TMO_WIDTH-1:0]   tmo_limit,
  input  logic                   err_clr,
  output logic                   start_conv,
  output logic [CHN_WIDTH-1:0]   cfg_ci,
  output logic [CHN_WIDTH-1:0]   cfg_co,
  output logic                   cfg_stride,
  output logic                   cfg_group,
  output logic [FMS_WIDTH-1:0]   cfg_ifm_size,
  input  logic                   conv_done,
  output logic                   busy,
  output logic                   layer_done,
  output logic [7:0]             layer_cnt,
  output logic [$clog2(DEPTH):0] fifo_cnt,
  output logic                   tmo_err,
  output logic [1:0]             o_dbg_state
);
  localparam int AW = $clog2(DEPTH);
  localparam int DW = 2 * CHN_WIDTH + 2 + FMS_WIDTH;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_RUN    = 2'd2,
    S_GAP    = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [DW-1:0]        r_mem [DEPTH];
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [AW:0]          r_cnt;
  logic [DW-1:0]        r_cfg;
  logic [TMO_WIDTH-1:0] r_wdt;
  logic [TMO_WIDTH-1:0] w_wdt_inc;
  logic [7:0]           r_layer_cnt;
  logic                 r_tmo_err;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_expire;
  logic                 w_done_run;

  assign desc.desc_ready = (r_cnt != FULL_CNT);
  assign w_push     = desc.desc_valid && desc.desc_ready;
  assign w_pop      = (r_state == S_IDLE) && sched_en && (r_cnt != '0) && !r_tmo_err;
  assign w_done_run = (r_state == S_RUN) && conv_done;

  // w_wdt_inc counts the current RUN cycle, so expiry lands tmo_limit+1 cycles after the launch edge.
  assign w_wdt_inc = r_wdt + TMO_WIDTH'(1);
  assign w_expire  = (r_state == S_RUN) && (tmo_limit != '0) && (w_wdt_inc == tmo_limit);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (w_pop) w_state_next = S_LAUNCH;
      S_LAUNCH: w_state_next = S_RUN;
      S_RUN: begin
        if (conv_done)     w_state_next = S_GAP;
        else if (w_expire) w_state_next = S_IDLE;
      end
      S_GAP:    w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Storage needs no reset: pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= {desc.desc_ci, desc.desc_co, desc.desc_stride,
                          desc.desc_group, desc.desc_ifm_size};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_cnt       <= '0;
      r_cfg       <= '0;
      r_wdt       <= '0;
      r_layer_cnt <= '0;
      r_tmo_err   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        r_cfg    <= r_mem[r_rd_ptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (AW + 1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW + 1)'(1);
        default: r_cnt <= r_cnt;
      endcase
      if (r_state == S_LAUNCH)   r_wdt <= '0;
      else if (r_state == S_RUN) r_wdt <= w_wdt_inc;
      if (w_done_run) r_layer_cnt <= r_layer_cnt + 8'd1;
      // A completing layer beats a coincident expiry; a new expiry beats err_clr.
      if (w_expire && !conv_done) r_tmo_err <= 1'b1;
      else if (err_clr)           r_tmo_err <= 1'b0;
    end
  end

  assign start_conv   = (r_state == S_LAUNCH);
  assign busy         = (r_state == S_LAUNCH) || (r_state == S_RUN);
  assign layer_done   = (r_state == S_GAP);
  assign layer_cnt    = r_layer_cnt;
  assign fifo_cnt     = r_cnt;
  assign tmo_err      = r_tmo_err;
  assign o_dbg_state  = r_state;
  assign cfg_ci       = r_cfg[DW-1 -: CHN_WIDTH];
  assign cfg_co       = r_cfg[DW-1-CHN_WIDTH -: CHN_WIDTH];
  assign cfg_stride   = r_cfg[FMS_WIDTH+1];
  assign cfg_group    = r_cfg[FMS_WIDTH];
  assign cfg_ifm_size = r_cfg[FMS_WIDTH-1:0];
endmodule

// File: tb/tb_conv_layer_sched.sv
// Directed/randomized bench for conv_layer_sched: a descriptor queue plus a layer
// counter model predict launch order, cfg values, timing and error behaviour.
module tb_conv_layer_sched;
  localparam int CW    = 4;
  localparam int FW    = 8;
  localparam int DEPTH = 4;
  localparam int TW    = 16;
  localparam int DW    = 2 * CW + 2 + FW;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          sched_en = 1'b0;
  logic          err_clr = 1'b0;
  logic          conv_done = 1'b0;
  logic [TW-1:0] tmo_limit = '0;
  logic          start_conv;
  logic [CW-1:0] cfg_ci;
  logic [CW-1:0] cfg_co;
  logic          cfg_stride;
  logic          cfg_group;
  logic [FW-1:0] cfg_ifm_size;
  logic          busy;
  logic          layer_done;
  logic [7:0]    layer_cnt;
  logic [2:0]    fifo_cnt;
  logic          tmo_err;
  logic [1:0]    dbg_state;

  conv_layer_sched_if #(.CHN_WIDTH(CW), .FMS_WIDTH(FW)) dif ();

  conv_layer_sched #(
    .CHN_WIDTH(CW), .FMS_WIDTH(FW), .DEPTH(DEPTH), .TMO_WIDTH(TW)
  ) dut (
    .clk(clk), .rstn(rstn), .sched_en(sched_en), .desc(dif),
    .tmo_limit(tmo_limit), .err_clr(err_clr), .start_conv(start_conv),
    .cfg_ci(cfg_ci), .cfg_co(cfg_co), .cfg_stride(cfg_stride), .cfg_group(cfg_group),
    .cfg_ifm_size(cfg_ifm_size), .conv_done(conv_done), .busy(busy),
    .layer_done(layer_done), .layer_cnt(layer_cnt), .fifo_cnt(fifo_cnt),
    .tmo_err(tmo_err), .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int            n_total = 0;
  int            n_pass = 0;
  int            m_layers = 0;
  logic [DW-1:0] exp_q[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic logic [DW-1:0] rand_desc();
    return DW'($urandom());
  endfunction

  // Drive one descriptor for one edge; the model accepts it only if not full.
  task automatic push_desc(input logic [DW-1:0] d);
    logic acc;
    acc = (exp_q.size() < DEPTH);
    chk("desc_ready", dif.desc_ready, acc);
    dif.desc_valid = 1'b1;
    {dif.desc_ci, dif.desc_co, dif.desc_stride, dif.desc_group, dif.desc_ifm_size} = d;
    step();
    dif.desc_valid = 1'b0;
    if (acc) exp_q.push_back(d);
  endtask

  task automatic launch_check();
    chk("start_conv", start_conv, 1);
    chk("busy_launch", busy, 1);
    if (exp_q.size() == 0) chk("launch_model_empty", start_conv, 0);
    else chk("cfg", {cfg_ci, cfg_co, cfg_stride, cfg_group, cfg_ifm_size}, exp_q.pop_front());
    chk("fifo_cnt_launch", fifo_cnt, exp_q.size());
  endtask

  // Called right after a launch edge; conv_done is sampled r cycles later.
  task automatic run_layer(input int r);
    step();
    for (int k = 1; k < r; k++) begin
      chk("busy_run", busy, 1);
      chk("start_run", start_conv, 0);
      step();
    end
    conv_done = 1'b1;
    step();
    conv_done = 1'b0;
    m_layers++;
    chk("layer_done", layer_done, 1);
    chk("busy_done", busy, 0);
    chk("tmo_err_done", tmo_err, 0);
    chk("layer_cnt", layer_cnt, m_layers % 256);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [DW-1:0] d;
    dif.desc_valid = 1'b0;
    {dif.desc_ci, dif.desc_co, dif.desc_stride, dif.desc_group, dif.desc_ifm_size} = '0;

    // Reset state
    #2 rstn = 1'b0;
    step(); step();
    chk("rst_start", start_conv, 0);
    chk("rst_busy", busy, 0);
    chk("rst_layer_done", layer_done, 0);
    chk("rst_layer_cnt", layer_cnt, 0);
    chk("rst_fifo_cnt", fifo_cnt, 0);
    chk("rst_tmo_err", tmo_err, 0);
    chk("rst_cfg", {cfg_ci, cfg_co, cfg_stride, cfg_group, cfg_ifm_size}, 0);
    chk("rst_desc_ready", dif.desc_ready, 1);
    rstn = 1'b1;
    step();

    // Single layer: launch in the cycle after the push, one-cycle start pulse
    sched_en = 1'b1;
    push_desc({4'd3, 4'd5, 1'b1, 1'b0, 8'd32});
    chk("single_no_start_yet", start_conv, 0);
    chk("single_fifo_one", fifo_cnt, 1);
    step();
    chk("single_cfg_ci", cfg_ci, 3);
    chk("single_cfg_ifm", cfg_ifm_size, 32);
    launch_check();
    run_layer(20);
    step();
    chk("single_done_one_cycle", layer_done, 0);
    chk("single_idle_busy", busy, 0);
    chk("single_cnt_hold", layer_cnt, 1);

    // Fill the FIFO while disabled, then drain back-to-back
    sched_en = 1'b0;
    for (int i = 0; i < 5; i++) push_desc(rand_desc());
    chk("fill_fifo_cnt", fifo_cnt, 4);
    chk("fill_ready_low", dif.desc_ready, 0);
    sched_en = 1'b1;
    step();
    launch_check();
    for (int i = 0; i < 4; i++) begin
      run_layer(int'($urandom_range(1, 6)));
      step();
      chk("gap_no_start", start_conv, 0);
      step();
      if (i < 3) launch_check();
      else chk("drained_no_start", start_conv, 0);
    end
    chk("drained_fifo", fifo_cnt, 0);

    // Watchdog expiry, FIFO still accepting, err_clr releases the queue
    sched_en = 1'b0;
    push_desc(rand_desc());
    push_desc(rand_desc());
    tmo_limit = 16'd10;
    sched_en = 1'b1;
    step();
    launch_check();
    for (int k = 1; k <= 10; k++) begin
      step();
      chk("wdt_not_yet", tmo_err, 0);
      chk("wdt_busy", busy, 1);
    end
    step();
    chk("wdt_err_set", tmo_err, 1);
    chk("wdt_busy_low", busy, 0);
    chk("wdt_no_layer_done", layer_done, 0);
    chk("wdt_cnt_hold", layer_cnt, m_layers % 256);
    push_desc(rand_desc());
    chk("wdt_fifo_accepts", fifo_cnt, 2);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("wdt_blocked", start_conv, 0);
    end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("wdt_cleared", tmo_err, 0);
    step();
    launch_check();
    tmo_limit = '0;
    run_layer(15);
    step(); step();
    launch_check();

    // conv_done on the expiry cycle wins
    tmo_limit = 16'd5;
    run_layer(5);

    // A new expiry wins over a coincident err_clr
    push_desc(rand_desc());
    step();
    launch_check();
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("set_vs_clr_pre", tmo_err, 0);
    end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("set_vs_clr", tmo_err, 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("clr_after", tmo_err, 0);
    tmo_limit = '0;

    // Push and pop on the same edge keep the count
    sched_en = 1'b0;
    push_desc(rand_desc());
    push_desc(rand_desc());
    sched_en = 1'b1;
    push_desc(rand_desc());
    launch_check();
    chk("push_pop_cnt", fifo_cnt, 2);

    // Disabling mid-run lets the layer finish and blocks the next launch
    step();
    sched_en = 1'b0;
    run_layer(4);
    for (int k = 0; k < 10; k++) begin
      step();
      chk("gated_no_start", start_conv, 0);
    end
    chk("gated_fifo", fifo_cnt, 2);

    // Run minimal layers until the completion counter wraps to 0
    sched_en = 1'b1;
    step();
    launch_check();
    run_layer(1);
    step(); step();
    launch_check();
    run_layer(1);
    while (m_layers % 256 != 0) begin
      push_desc(rand_desc());
      step();
      launch_check();
      run_layer(1);
    end
    chk("wrap_zero", layer_cnt, 0);

    // Asynchronous reset mid-run with three queued
    sched_en = 1'b0;
    for (int i = 0; i < 4; i++) push_desc(rand_desc());
    sched_en = 1'b1;
    step();
    launch_check();
    step();
    chk("pre_rst_busy", busy, 1);
    #3 rstn = 1'b0;
    #1;
    exp_q.delete();
    m_layers = 0;
    chk("arst_busy", busy, 0);
    chk("arst_start", start_conv, 0);
    chk("arst_fifo", fifo_cnt, 0);
    chk("arst_layer_cnt", layer_cnt, 0);
    chk("arst_cfg", {cfg_ci, cfg_co, cfg_stride, cfg_group, cfg_ifm_size}, 0);
    chk("arst_ready", dif.desc_ready, 1);
    @(posedge clk);
    #1 rstn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("post_rst_no_start", start_conv, 0);
    end
    push_desc(rand_desc());
    step();
    launch_check();
    run_layer(3);
    chk("post_rst_cnt", layer_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
